md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Multi-cycle multiply/divide unit; parametrised successor to the single-cycle ALU.
//  Computes MULT/MULTU/DIV/DIVU into a private HI/LO register pair with a start/busy/done handshake.
//  Also executes MTHI/MTLO. Sits beside the ALU in EX; the pipeline stalls on mfhi/mflo while busy.
// PARAMETERS
//  WIDTH   32   operand/result width; HI and LO are each WIDTH bits.
// PORTS
//  clk      in   1      rising-edge clock
//  rst      in   1      synchronous, active-high reset
//  start    in   1      request; accepted only when busy=0
//  md_op    in   3      000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NOP
//  a        in   WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
//  b        in   WIDTH  rt operand (divisor / multiplier)
//  flush    in   1      cancel any operation in flight (pipeline exception)
//  busy     out  1      operation in flight; HI/LO reads must stall
//  done     out  1      one-cycle pulse in the cycle HI/LO take the new result
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
//  div0     out  1      (MD_DIV0_FLAG_EN only) one-cycle pulse: DIV/DIVU with b==0 accepted
// BEHAVIOUR
//  - Reset: hi=0, lo=0, busy=0, done=0, div0=0, state=IDLE; any operation in flight is discarded.
//  - States: IDLE -> CALC (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
//  - IDLE, start & MULT/MULTU/DIV/DIVU: latch |a|, |b| (signed ops) or a, b; record result signs;
//    clear counter; go to CALC. busy=1 from the next cycle.
//  - IDLE, start & MTHI/MTLO: hi<=a or lo<=a at that edge; busy stays 0; done stays 0.
//  - start with NOP op, or any start while busy=1: ignored (no queuing).
//  - CALC: one radix-2 step per cycle. MUL: shift-add into 2*WIDTH product.
//    DIV: restoring shift-subtract. Counter runs 0..WIDTH-1, then FIX.
//  - FIX: apply sign correction. At the FIX->IDLE edge: hi/lo updated, done=1 for one cycle, busy=0.
//    Latency: start edge to done = WIDTH+2 cycles; busy high for WIDTH+1 cycles.
//  - MULT/MULTU: {hi,lo} = full 2*WIDTH product (signed or unsigned).
//  - DIV: lo = quotient truncated toward zero; hi = remainder, same sign as dividend.
//    MIN/-1: lo=MIN, hi=0 (no trap). DIVU: unsigned quotient/remainder.
//  - Divide by zero (any DIV/DIVU): full latency, lo = all ones, hi = a (raw dividend).
//  - hi/lo hold their previous values throughout CALC/FIX.
//  - flush: in CALC/FIX -> IDLE next edge, busy=0, done=0, hi/lo unchanged.
//    In IDLE, flush outranks start: op dropped, including MTHI/MTLO.
//  - rst outranks flush and start.
//  - Back-to-back: start is accepted in the cycle done=1, since busy=0 there.
// CONFIGURATION
//  MD_DIV0_FLAG_EN defined:
//    - div0 port present; pulses 1 cycle at the accept edge of DIV/DIVU when b==0.
//    - Operation still runs to completion with the zero-divisor result above.
//  MD_DIV0_FLAG_EN undefined:
//    - div0 port and logic absent; zero-divisor result identical.
// TESTING (WIDTH=32)
//  - MULTU a=7 b=6 -> done exactly 34 cycles after accept; hi=0, lo=0x0000002A; busy low same cycle.
//  - MULT a=0xFFFFFFFE b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  - DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//    DIVU a=0x80000000 b=3 -> lo=0x2AAAAAAA, hi=2.
//  - DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
//    DIV a=5 b=0 -> lo=0xFFFFFFFF, hi=5; div0 pulse only with macro.
//  - MULT started, flush at cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged;
//    new start then accepted immediately.
//  - Start while busy ignored; MTLO a=0x1234 in IDLE -> lo=0x1234 next edge, no done;
//    rst mid-CALC -> hi=lo=0, busy=0.

Source files
------------

// File: rtl/md_unit_if.sv
// Request/response bundle between the EX stage and md_unit.
// Carries div0 only when MD_DIV0_FLAG_EN is defined.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MD_DIV0_FLAG_EN
  logic             div0;

  modport master (output start, md_op, a, b, flush,
                  input  busy, done, hi, lo, div0);
  modport slave  (input  start, md_op, a, b, flush,
                  output busy, done, hi, lo, div0);
`else
  modport master (output start, md_op, a, b, flush,
                  input  busy, done, hi, lo);
  modport slave  (input  start, md_op, a, b, flush,
                  output busy, done, hi, lo);
`endif
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO (radix-2 shift-add / restoring divide).
// Optional feature macro: MD_DIV0_FLAG_EN adds the one-cycle div0 pulse on zero-divisor accept.
module md_unit #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  md_unit_if.slave md
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   d;
  logic               is_div, neg_q, neg_r, dz;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic op_arith, op_signed, op_div;
  logic accept, mt_hi, mt_lo, last;
  logic [WIDTH-1:0] ua, ub;

  always_comb begin
    op_arith  = (md.md_op >= 3'd1) && (md.md_op <= 3'd4);
    op_signed = (md.md_op == 3'd1) || (md.md_op == 3'd3);
    op_div    = (md.md_op == 3'd3) || (md.md_op == 3'd4);
    ua = (op_signed && md.a[WIDTH-1]) ? -md.a : md.a;
    ub = (op_signed && md.b[WIDTH-1]) ? -md.b : md.b;
    last = (cnt == CW'(WIDTH-1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (md.start && !md.flush && op_arith) nxt = CALC;
      CALC:    if (md.flush) nxt = IDLE;
               else if (last) nxt = FIX;
      FIX:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    md.busy = (state != IDLE);
    accept  = (state == IDLE) && md.start && !md.flush && op_arith;
    mt_hi   = (state == IDLE) && md.start && !md.flush && (md.md_op == 3'd5);
    mt_lo   = (state == IDLE) && md.start && !md.flush && (md.md_op == 3'd6);
  end

  // One radix-2 step for each datapath; p holds {acc,multiplier} or {remainder,quotient}.
  logic [WIDTH:0]     sum, sh;
  logic [WIDTH-1:0]   diffw, rem_n;
  logic               ge;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   qv, rv, hi_res, lo_res;

  always_comb begin
    sum      = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, d} : '0);
    mul_next = {sum, p[WIDTH-1:1]};
    sh       = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    ge       = (sh >= {1'b0, d});
    diffw    = sh[WIDTH-1:0] - d;
    rem_n    = ge ? diffw : sh[WIDTH-1:0];
    div_next = {rem_n, p[WIDTH-2:0], ge};

    prod = neg_q ? -p : p;
    qv   = p[WIDTH-1:0];
    rv   = p[2*WIDTH-1:WIDTH];
    if (is_div) begin
      // With a zero divisor the remainder path has shifted in |a|, so sign-fixing restores raw a.
      lo_res = dz ? '1 : (neg_q ? -qv : qv);
      hi_res = neg_r ? -rv : rv;
    end else begin
      lo_res = prod[WIDTH-1:0];
      hi_res = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      p      <= '0;
      d      <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            p      <= op_div ? {{WIDTH{1'b0}}, ua} : {{WIDTH{1'b0}}, ub};
            d      <= op_div ? ub : ua;
            cnt    <= '0;
            is_div <= op_div;
            neg_q  <= op_signed && (md.a[WIDTH-1] ^ md.b[WIDTH-1]);
            neg_r  <= op_signed && md.a[WIDTH-1];
            dz     <= op_div && (md.b == '0);
          end else if (mt_hi) begin
            hi_q <= md.a;
          end else if (mt_lo) begin
            lo_q <= md.a;
          end
        end
        CALC: begin
          p   <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (!md.flush) begin
            hi_q   <= hi_res;
            lo_q   <= lo_res;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
  assign md.done = done_q;

`ifdef MD_DIV0_FLAG_EN
  logic div0_q;
  always_ff @(posedge clk) begin
    if (rst) div0_q <= 1'b0;
    else     div0_q <= accept && op_div && (md.b == '0);
  end
  assign md.div0 = div0_q;
`endif
endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit at WIDTH=32.
module tb_md_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  md_unit_if #(.WIDTH(W)) mif ();
  md_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .md(mif));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one arithmetic op, wait for done, check latency and result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo);
    int lat, bcnt, d0cnt;
    logic d0first;
    mif.start = 1'b1; mif.md_op = op; mif.a = av; mif.b = bv;
    step();
    mif.start = 1'b0; mif.md_op = 3'd0;
    lat = 1; bcnt = 0; d0cnt = 0; d0first = 1'b0;
`ifdef MD_DIV0_FLAG_EN
    d0first = mif.div0;
`endif
    while (!mif.done && lat < 200) begin
      if (mif.busy) bcnt++;
`ifdef MD_DIV0_FLAG_EN
      if (mif.div0) d0cnt++;
`endif
      step();
      lat++;
    end
    check({tag, ".lat"}, lat, 34);
    check({tag, ".busy_cycles"}, bcnt, 33);
    check({tag, ".busy_at_done"}, mif.busy, 1'b0);
    check({tag, ".hi"}, mif.hi, ehi);
    check({tag, ".lo"}, mif.lo, elo);
`ifdef MD_DIV0_FLAG_EN
    check({tag, ".div0_first"}, d0first, ((op == 3'd3 || op == 3'd4) && bv == 0));
    check({tag, ".div0_cnt"}, d0cnt, ((op == 3'd3 || op == 3'd4) && bv == 0) ? 1 : 0);
`endif
  endtask

  initial begin
    int lat, dn;
    rst = 1'b1;
    mif.start = 1'b0; mif.md_op = 3'd0; mif.a = '0; mif.b = '0; mif.flush = 1'b0;
    repeat (3) step();
    check("reset.hi", mif.hi, 0);
    check("reset.lo", mif.lo, 0);
    check("reset.busy", mif.busy, 0);
    check("reset.done", mif.done, 0);
    rst = 1'b0;
    step();

    run_op("multu_7x6", 3'd2, 32'd7, 32'd6, 32'h0, 32'h2A);
    run_op("mult_neg", 3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_b2b", 3'd4, 32'h80000000, 32'd3, 32'd2, 32'h2AAAAAAA);
    run_op("divu_bigdiv", 3'd4, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'h1);
    run_op("div_min_m1", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("div_5_by0", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run_op("div_m7_by0", 3'd3, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    step();

    // Flush at cycle 10 of a MULT: no done, HI/LO keep the div-by-zero result.
    mif.start = 1'b1; mif.md_op = 3'd1; mif.a = 32'd3; mif.b = 32'd5;
    step();
    mif.start = 1'b0; mif.md_op = 3'd0;
    lat = 1;
    while (lat < 10) begin step(); lat++; end
    mif.flush = 1'b1;
    step();
    mif.flush = 1'b0;
    check("flush.busy", mif.busy, 0);
    check("flush.done", mif.done, 0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin if (mif.done) dn++; step(); end
    check("flush.no_done", dn, 0);
    check("flush.hi", mif.hi, 32'hFFFFFFF9);
    check("flush.lo", mif.lo, 32'hFFFFFFFF);
    run_op("after_flush", 3'd2, 32'd3, 32'd5, 32'h0, 32'd15);

    // Starts while busy (MTLO then DIVU) must be ignored.
    mif.start = 1'b1; mif.md_op = 3'd2; mif.a = 32'd2; mif.b = 32'd3;
    step();
    mif.start = 1'b0; mif.md_op = 3'd0;
    lat = 1;
    while (!mif.done && lat < 200) begin
      mif.start = (lat == 5) || (lat == 6);
      mif.md_op = (lat == 5) ? 3'd6 : 3'd4;
      mif.a = 32'hDEAD; mif.b = 32'd7;
      step();
      lat++;
    end
    mif.start = 1'b0; mif.md_op = 3'd0;
    check("busy_start.lat", lat, 34);
    check("busy_start.lo", mif.lo, 32'd6);
    check("busy_start.hi", mif.hi, 32'd0);
    step();
    check("busy_start.idle", mif.busy, 0);

    // MTLO / MTHI in IDLE.
    mif.start = 1'b1; mif.md_op = 3'd6; mif.a = 32'h1234;
    step();
    mif.start = 1'b0; mif.md_op = 3'd0;
    check("mtlo.lo", mif.lo, 32'h1234);
    check("mtlo.hi", mif.hi, 32'h0);
    check("mtlo.busy", mif.busy, 0);
    check("mtlo.done", mif.done, 0);
    mif.start = 1'b1; mif.md_op = 3'd5; mif.a = 32'hABCD;
    step();
    mif.start = 1'b0; mif.md_op = 3'd0;
    check("mthi.hi", mif.hi, 32'hABCD);
    check("mthi.lo", mif.lo, 32'h1234);

    // Flush outranks start in IDLE, and NOP starts do nothing.
    mif.start = 1'b1; mif.md_op = 3'd5; mif.a = 32'h5555; mif.flush = 1'b1;
    step();
    mif.start = 1'b0; mif.flush = 1'b0;
    check("flush_mthi.hi", mif.hi, 32'hABCD);
    check("flush_mthi.busy", mif.busy, 0);
    mif.start = 1'b1; mif.md_op = 3'd7; mif.a = 32'h7777;
    step();
    mif.md_op = 3'd0;
    step();
    mif.start = 1'b0;
    check("nop.busy", mif.busy, 0);
    check("nop.hi", mif.hi, 32'hABCD);
    check("nop.lo", mif.lo, 32'h1234);

    // Reset mid-CALC clears HI/LO and drops the operation.
    mif.start = 1'b1; mif.md_op = 3'd1; mif.a = 32'hFFFFFFFE; mif.b = 32'd3;
    step();
    mif.start = 1'b0; mif.md_op = 3'd0;
    repeat (7) step();
    check("pre_rst.busy", mif.busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid.hi", mif.hi, 0);
    check("rst_mid.lo", mif.lo, 0);
    check("rst_mid.busy", mif.busy, 0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin if (mif.done) dn++; step(); end
    check("rst_mid.no_done", dn, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
